// File: rtl/series_eval_if.sv
// Request/result handshake bundle between the command front-end and the
// series evaluation sequencer.
interface series_eval_if #(
  parameter int unsigned CNTR_DEPTH = 5,
  parameter int unsigned DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [CNTR_DEPTH-1:0] req_nterms;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_data;

  modport master (
    output req_valid, req_nterms, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_nterms, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/series_eval_ctrl.sv
// Power-series evaluation sequencer: clears the MAC, walks the coefficient
// ROM, aligns MAC enables to ROM latency, drains the MAC pipeline and hands
// the accumulated result back over a valid/ready handshake.
// Optional feature macro: SERIES_ABORT_EN adds an 'abort' input that cancels
// a running evaluation (CLEAR/ISSUE/DRAIN) without producing a result.
module series_eval_ctrl #(
  parameter int unsigned CNTR_DEPTH = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned MAC_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SERIES_ABORT_EN
  input  logic                  abort,
`endif
  series_eval_if.slave          bus,
  output logic                  coeff_rd_en,
  output logic [CNTR_DEPTH-1:0] coeff_addr,
  output logic [CNTR_DEPTH-1:0] term_cnt,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  mac_last,
  input  logic [DATA_W-1:0]     acc_in,
  output logic                  busy
);

  localparam int unsigned       DRAIN_CYC  = ROM_LAT + MAC_LAT;
  localparam int unsigned       DRAIN_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, RESULT} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNTR_DEPTH-1:0] n_lat;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [ROM_LAT-1:0]    en_pipe;
  logic [ROM_LAT-1:0]    last_pipe;
  logic [DATA_W-1:0]     res_q;
  logic                  accept;
  logic                  is_last;
  logic                  abort_hit;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign is_last = (term_cnt == (n_lat - CNTR_DEPTH'(1)));

`ifdef SERIES_ABORT_EN
  assign abort_hit = abort && (state inside {CLEAR, ISSUE, DRAIN});
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; abort overrides every in-flight transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = (bus.req_nterms == '0) ? RESULT : CLEAR;
      CLEAR:   state_next = ISSUE;
      ISSUE:   if (is_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Control outputs decoded purely from the state register.
  always_comb begin
    bus.req_ready = (state == IDLE);
    busy          = (state != IDLE);
    mac_clr       = (state == CLEAR);
    coeff_rd_en   = (state == ISSUE);
    bus.res_valid = (state == RESULT);
  end

  assign coeff_addr   = term_cnt;
  assign mac_en       = en_pipe[ROM_LAT-1];
  assign mac_last     = last_pipe[ROM_LAT-1];
  assign bus.res_data = res_q;

  // Term count latched on accept.
  always_ff @(posedge clk) begin
    if (!rst_n)      n_lat <= '0;
    else if (accept) n_lat <= bus.req_nterms;
  end

  // Term index: advances through ISSUE, holds at N-1 afterwards, zero in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n)                                      term_cnt <= '0;
    else if (state_next == IDLE)                     term_cnt <= '0;
    else if (state == ISSUE && state_next == ISSUE)  term_cnt <= term_cnt + CNTR_DEPTH'(1);
  end

  // ROM-latency delay line turning read enables into MAC enables.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit) begin
      en_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      en_pipe   <= (en_pipe << 1)   | ROM_LAT'(coeff_rd_en);
      last_pipe <= (last_pipe << 1) | ROM_LAT'(coeff_rd_en && is_last);
    end
  end

  // Drain counter covering the ROM plus MAC pipeline after the last read.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit)                          drain_cnt <= '0;
    else if (state == ISSUE && state_next == DRAIN)   drain_cnt <= DRAIN_INIT;
    else if (state == DRAIN && drain_cnt != '0)       drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  // Result capture: zero for an empty series, otherwise the settled accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n)                                                res_q <= '0;
    else if (accept && bus.req_nterms == '0)                   res_q <= '0;
    else if (state == DRAIN && drain_cnt == '0 && !abort_hit)  res_q <= acc_in;
  end

endmodule

// File: tb/tb_series_eval_ctrl.sv
// Directed bench for series_eval_ctrl: reset, nominal, empty series,
// backpressure, back-to-back, maximum length, reset mid-run, and abort when
// SERIES_ABORT_EN is defined.
module tb_series_eval_ctrl;
  localparam int unsigned CNTR_DEPTH = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ROM_LAT    = 2;
  localparam int unsigned MAC_LAT    = 3;
  localparam int unsigned PIPE       = ROM_LAT + MAC_LAT;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  coeff_rd_en;
  logic [CNTR_DEPTH-1:0] coeff_addr;
  logic [CNTR_DEPTH-1:0] term_cnt;
  logic                  mac_clr;
  logic                  mac_en;
  logic                  mac_last;
  logic [DATA_W-1:0]     acc_in;
  logic                  busy;
`ifdef SERIES_ABORT_EN
  logic                  abort;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  series_eval_if #(.CNTR_DEPTH(CNTR_DEPTH), .DATA_W(DATA_W)) bus ();

  series_eval_ctrl #(
    .CNTR_DEPTH(CNTR_DEPTH),
    .DATA_W    (DATA_W),
    .ROM_LAT   (ROM_LAT),
    .MAC_LAT   (MAC_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SERIES_ABORT_EN
    .abort      (abort),
`endif
    .bus        (bus),
    .coeff_rd_en(coeff_rd_en),
    .coeff_addr (coeff_addr),
    .term_cnt   (term_cnt),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .mac_last   (mac_last),
    .acc_in     (acc_in),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One evaluation accepted in the current cycle (c0), checked cycle by cycle
  // up to the result, held 'hold' cycles under backpressure, then released.
  task automatic run_eval(input int unsigned n, input logic [DATA_W-1:0] acc_val,
                          input int unsigned hold);
    int unsigned t_res;
    t_res = (n == 0) ? 1 : n + 2 + PIPE;
    check($sformatf("req_ready_c0_n%0d", n), bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_nterms = CNTR_DEPTH'(n);
    for (int unsigned t = 1; t <= t_res; t++) begin
      step();
      bus.req_valid = 1'b0;
      acc_in = (n != 0 && t == t_res - 1) ? acc_val : (32'hDEAD_0000 | t);
      check($sformatf("mac_clr_n%0d_c%0d", n, t), mac_clr, (n != 0 && t == 1));
      check($sformatf("rd_en_n%0d_c%0d", n, t), coeff_rd_en, (n != 0 && t >= 2 && t <= n + 1));
      if (n != 0 && t >= 2 && t < t_res)
        check($sformatf("addr_n%0d_c%0d", n, t), coeff_addr, (t <= n + 1) ? t - 2 : n - 1);
      check($sformatf("mac_en_n%0d_c%0d", n, t), mac_en,
            (n != 0 && t >= 2 + ROM_LAT && t <= n + 1 + ROM_LAT));
      check($sformatf("mac_last_n%0d_c%0d", n, t), mac_last, (n != 0 && t == n + 1 + ROM_LAT));
      check($sformatf("res_valid_n%0d_c%0d", n, t), bus.res_valid, (t == t_res));
      check($sformatf("busy_n%0d_c%0d", n, t), busy, 1);
    end
    check($sformatf("res_data_n%0d", n), bus.res_data, (n == 0) ? '0 : acc_val);
    for (int unsigned h = 0; h < hold; h++) begin
      bus.req_valid  = (h == 1);
      bus.req_nterms = 5'd3;
      step();
      check($sformatf("hold_res_valid_%0d", h), bus.res_valid, 1);
      check($sformatf("hold_res_data_%0d", h), bus.res_data, (n == 0) ? '0 : acc_val);
      check($sformatf("hold_req_ready_%0d", h), bus.req_ready, 0);
      check($sformatf("hold_mac_clr_%0d", h), mac_clr, 0);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check($sformatf("idle_req_ready_n%0d", n), bus.req_ready, 1);
    check($sformatf("idle_busy_n%0d", n), busy, 0);
    check($sformatf("idle_res_valid_n%0d", n), bus.res_valid, 0);
    check($sformatf("idle_term_cnt_n%0d", n), term_cnt, 0);
  endtask

  // Watch a quiet window after an interrupted evaluation.
  task automatic expect_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 15; i++) begin
      step();
      if (bus.res_valid || mac_en || coeff_rd_en) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_nterms = '0;
    bus.res_ready  = 1'b0;
    acc_in         = '0;
`ifdef SERIES_ABORT_EN
    abort          = 1'b0;
`endif
    repeat (3) step();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_rd_en", coeff_rd_en, 0);
    check("rst_addr", coeff_addr, 0);
    check("rst_term_cnt", term_cnt, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_mac_last", mac_last, 0);
    rst_n = 1'b1;
    step();

    run_eval(4, 32'h0000_1234, 0);
    run_eval(0, 32'hFFFF_FFFF, 0);
    run_eval(2, 32'hA5A5_0002, 5);
    run_eval(1, 32'h0000_0777, 0);
    run_eval(31, 32'hCAFE_F00D, 0);

    // Reset asserted mid-ISSUE at term index 3 of a 6-term evaluation.
    bus.req_valid  = 1'b1;
    bus.req_nterms = 5'd6;
    step();
    bus.req_valid = 1'b0;
    repeat (4) step();
    check("rst_mid_pre_addr", coeff_addr, 3);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_mid_req_ready", bus.req_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_en", coeff_rd_en, 0);
    check("rst_mid_mac_en", mac_en, 0);
    check("rst_mid_res_valid", bus.res_valid, 0);
    expect_quiet("rst_mid_no_result");
    run_eval(3, 32'h0000_0333, 0);

`ifdef SERIES_ABORT_EN
    // Abort at ISSUE term index 5 of an 8-term evaluation.
    bus.req_valid  = 1'b1;
    bus.req_nterms = 5'd8;
    step();
    bus.req_valid = 1'b0;
    repeat (6) step();
    check("abort_pre_addr", coeff_addr, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_req_ready", bus.req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rd_en", coeff_rd_en, 0);
    check("abort_mac_en", mac_en, 0);
    check("abort_term_cnt", term_cnt, 0);
    expect_quiet("abort_no_result");
    run_eval(1, 32'h0000_0BEE, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
